morse_tx_queue: RTL and testbench

Parametrised Morse transmitter: queues letter codes in a FIFO, expands each into on/off keying units, and drives a single keyed output at a programmable unit rate.
Supersedes the fixed 10-letter, 140-bit buffer-plus-shifter path.
Adds variable-length symbols, automatic inter-letter and word gaps, full/overflow reporting, repeat mode and flush.
Sits between the letter-entry front end (switches/keys) and the LED/buzzer output.

---
 rtl/morse_pkg.sv | 60 ++++++
 rtl/morse_lut.sv | 57 +++++
 rtl/morse_tx_queue.sv | 192 +++++++++++++++++++
 tb/tb_morse_tx_queue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types, widths and the dot/dash-to-keying expansion for the Morse transmitter.
package morse_pkg;

  localparam int PAT_W  = 14;
  localparam int LEN_W  = 4;
  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] SPACE_CODE = 5'd26;
  localparam int                GAP_UNITS  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SYMBOL,
    GAP
  } state_e;

  typedef struct packed {
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
  } symbol_t;

  // Letters and the word space are the only codes that may enter the queue.
  function automatic logic code_valid(input logic [CODE_W-1:0] code);
    return code <= SPACE_CODE;
  endfunction

  // Expands up to four elements (dashes[3] is the first element, 1 = dash)
  // into an MSB-first on/off unit pattern with one off unit between elements.
  function automatic symbol_t build_symbol(input logic [2:0] n_elem,
                                           input logic [3:0] dashes);
    symbol_t          s;
    logic [PAT_W-1:0] acc;
    logic [LEN_W-1:0] len;
    logic [3:0]       d;
    acc = '0;
    len = '0;
    d   = dashes;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n_elem) begin
        if (i > 0) begin
          acc = {acc[PAT_W-2:0], 1'b0};
          len = len + LEN_W'(1);
        end
        if (d[3]) begin
          acc = {acc[PAT_W-4:0], 3'b111};
          len = len + LEN_W'(3);
        end else begin
          acc = {acc[PAT_W-2:0], 1'b1};
          len = len + LEN_W'(1);
        end
        d = {d[2:0], 1'b0};
      end
    end
    s.pat = acc << (PAT_W - int'(len));
    s.len = len;
    return s;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Letter code to keying pattern lookup. Word space is four off units;
// codes above the space yield an empty pattern of length zero.
module morse_lut
  import morse_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [PAT_W-1:0]  pat_o,
  output logic [LEN_W-1:0]  len_o
);

  // {element count, dash flags first-element-first}
  logic [6:0] elem;
  symbol_t    sym;

  // Element table followed by expansion into units.
  always_comb begin
    elem = 7'b000_0000;
    case (code_i)
      5'd0:  elem = 7'b010_0100; // A .-
      5'd1:  elem = 7'b100_1000; // B -...
      5'd2:  elem = 7'b100_1010; // C -.-.
      5'd3:  elem = 7'b011_1000; // D -..
      5'd4:  elem = 7'b001_0000; // E .
      5'd5:  elem = 7'b100_0010; // F ..-.
      5'd6:  elem = 7'b011_1100; // G --.
      5'd7:  elem = 7'b100_0000; // H ....
      5'd8:  elem = 7'b010_0000; // I ..
      5'd9:  elem = 7'b100_0111; // J .---
      5'd10: elem = 7'b011_1010; // K -.-
      5'd11: elem = 7'b100_0100; // L .-..
      5'd12: elem = 7'b010_1100; // M --
      5'd13: elem = 7'b010_1000; // N -.
      5'd14: elem = 7'b011_1110; // O ---
      5'd15: elem = 7'b100_0110; // P .--.
      5'd16: elem = 7'b100_1101; // Q --.-
      5'd17: elem = 7'b011_0100; // R .-.
      5'd18: elem = 7'b011_0000; // S ...
      5'd19: elem = 7'b001_1000; // T -
      5'd20: elem = 7'b011_0010; // U ..-
      5'd21: elem = 7'b100_0001; // V ...-
      5'd22: elem = 7'b011_0110; // W .--
      5'd23: elem = 7'b100_1001; // X -..-
      5'd24: elem = 7'b100_1011; // Y -.--
      5'd25: elem = 7'b100_1100; // Z --..
      default: elem = 7'b000_0000;
    endcase

    sym   = build_symbol(elem[6:4], elem[3:0]);
    pat_o = sym.pat;
    len_o = sym.len;
    if (code_i == SPACE_CODE) begin
      pat_o = '0;
      len_o = LEN_W'(4);
    end
  end

endmodule

// File: rtl/morse_tx_queue.sv
// Queued Morse transmitter: letter FIFO, unit-rate divider and keying FSM.
module morse_tx_queue
  import morse_pkg::*;
#(
  parameter int DEPTH       = 10,
  parameter int UNIT_CYCLES = 25000000,
  parameter int REPEAT      = 0
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [4:0]                 in_i,
  input  logic                       load_i,
  input  logic                       show_i,
  input  logic                       clear_i,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       out_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DIV_W = $clog2(UNIT_CYCLES);

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(UNIT_CYCLES - 1);
  localparam logic [1:0]       GAP_INIT   = 2'(GAP_UNITS);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CODE_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rep_idx_q, rep_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       gap_q, gap_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic              full;
  logic              pop;
  logic              push;
  logic              valid_in;
  logic              timing;
  logic              tick;
  logic [PTR_W-1:0]  rd_addr;
  logic [CODE_W-1:0] rd_code;
  logic [PAT_W-1:0]  lut_pat;
  logic [LEN_W-1:0]  lut_len;

  assign full     = (count_q == FULL_CNT);
  assign valid_in = code_valid(in_i);
  // In repeat mode the queue is never drained; FETCH only reads.
  assign pop      = (state_q == FETCH) && (REPEAT == 0);
  // A pop in the same cycle frees the slot being written, so full is not a blocker then.
  assign push     = load_i && valid_in && (!full || pop);
  assign timing   = (state_q == SYMBOL) || (state_q == GAP);
  assign tick     = timing && (div_q == '0);

  assign rd_addr  = (REPEAT != 0) ? rep_idx_q : rd_ptr_q;
  assign rd_code  = mem_q[rd_addr];

  morse_lut u_lut (
    .code_i (rd_code),
    .pat_o  (lut_pat),
    .len_o  (lut_len)
  );

  // Queue storage; contents need no reset because count gates every read.
  always_ff @(posedge clock_i) begin
    if (!reset_i && !clear_i && push) begin
      mem_q[wr_ptr_q] <= in_i;
    end
  end

  // Queue pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (load_i && valid_in && full && !pop) overflow_d = 1'b1;
    end
  end

  // Unit divider: held at reload outside SYMBOL/GAP so each unit is exactly UNIT_CYCLES long.
  always_comb begin
    div_d = div_q - DIV_W'(1);
    if (clear_i || !timing || tick) div_d = DIV_RELOAD;
  end

  // Keying FSM next state.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    len_d     = len_q;
    gap_d     = gap_q;
    rep_idx_d = rep_idx_q;
    case (state_q)
      IDLE: begin
        if (show_i && (count_q != '0)) begin
          state_d   = FETCH;
          rep_idx_d = rd_ptr_q;
        end
      end
      FETCH: begin
        shreg_d   = lut_pat;
        len_d     = lut_len;
        state_d   = SYMBOL;
        rep_idx_d = (ptr_inc(rep_idx_q) == wr_ptr_q) ? rd_ptr_q : ptr_inc(rep_idx_q);
      end
      SYMBOL: begin
        if (tick) begin
          if (len_q == LEN_W'(1)) begin
            state_d = GAP;
            gap_d   = GAP_INIT;
          end else begin
            shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
            len_d   = len_q - LEN_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == 2'd1) begin
            state_d = (count_q != '0) ? FETCH : IDLE;
          end else begin
            gap_d = gap_q - 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rep_idx_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      shreg_q    <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      div_q      <= DIV_RELOAD;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rep_idx_q  <= rep_idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      div_q      <= div_d;
    end
  end

  assign out_o      = (state_q == SYMBOL) && shreg_q[PAT_W-1];
  assign busy_o     = (state_q != IDLE);
  assign ready_o    = !full;
  assign overflow_o = overflow_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_morse_tx_queue.sv
// Self-checking bench: a waveform model built from dot/dash strings predicts
// the keyed output, clock by clock, for queued letter sequences.
module tb_morse_tx_queue;

  localparam int U     = 4;
  localparam int UR    = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       show = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] in_code = 5'd0;

  logic       ready, busy, overflow, out;
  logic [2:0] count;
  logic       r_ready, r_busy, r_overflow, r_out;
  logic [2:0] r_count;

  always #5 clk = ~clk;

  morse_tx_queue #(.DEPTH(DEPTH), .UNIT_CYCLES(U), .REPEAT(0)) dut (
    .clock_i(clk), .reset_i(reset), .in_i(in_code), .load_i(load),
    .show_i(show), .clear_i(clear), .ready_o(ready), .busy_o(busy),
    .overflow_o(overflow), .count_o(count), .out_o(out)
  );

  morse_tx_queue #(.DEPTH(DEPTH), .UNIT_CYCLES(UR), .REPEAT(1)) dut_rep (
    .clock_i(clk), .reset_i(reset), .in_i(in_code), .load_i(load),
    .show_i(show), .clear_i(clear), .ready_o(r_ready), .busy_o(r_busy),
    .overflow_o(r_overflow), .count_o(r_count), .out_o(r_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  string morse_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                           "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                           "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                           "-.--", "--.."};

  // Appends the expected out level per clock for one letter: fetch clock,
  // elements (dot 1 unit, dash 3, 1 off between), then 3 off units.
  task automatic model_letter(input int code, input int u);
    string s;
    exp_q.push_back(1'b0);
    if (code == 26) begin
      repeat (4 * u) exp_q.push_back(1'b0);
    end else begin
      s = morse_tab[code];
      for (int i = 0; i < s.len(); i++) begin
        if (i > 0) repeat (u) exp_q.push_back(1'b0);
        repeat ((s[i] == "-") ? 3 * u : u) exp_q.push_back(1'b1);
      end
    end
    repeat (3 * u) exp_q.push_back(1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; show = 1'b0; clear = 1'b0; in_code = 5'd0;
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_load(input int code);
    load = 1'b1; in_code = 5'(code);
    step();
    load = 1'b0;
  endtask

  task automatic do_show();
    show = 1'b1;
    step();
    show = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({ready, busy, overflow, count, out} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: ready=%b busy=%b ovf=%b count=%0d out=%b, required 1 0 0 0 0",
               ready, busy, overflow, count, out);
    end
    n_checks++;
    if ({r_ready, r_busy, r_overflow, r_count, r_out} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_rep: ready=%b busy=%b ovf=%b count=%0d out=%b, required 1 0 0 0 0",
               r_ready, r_busy, r_overflow, r_count, r_out);
    end
  endtask

  task automatic test_single_e();
    do_reset();
    do_load(4);
    model_letter(4, U);
    do_show();
    foreach (exp_q[k]) begin
      n_checks++;
      if (out !== exp_q[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_e cycle %0d: out=%b busy=%b, required out=%b busy=1", k, out, busy, exp_q[k]);
      end
      if (k < 2) begin
        n_checks++;
        if (count !== ((k == 0) ? 3'd1 : 3'd0)) begin
          n_fail++;
          $display("FAIL single_e_count cycle %0d: count=%0d, required %0d", k, count, (k == 0) ? 1 : 0);
        end
      end
      step();
    end
    n_checks++;
    if (busy !== 1'b0 || out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_e_end: busy=%b out=%b, required 0 0", busy, out);
    end
  endtask

  task automatic test_two_letters();
    do_reset();
    do_load(0);
    do_load(19);
    model_letter(0, U);
    model_letter(19, U);
    do_show();
    foreach (exp_q[k]) begin
      n_checks++;
      if (out !== exp_q[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL a_t cycle %0d: out=%b busy=%b, required out=%b busy=1", k, out, busy, exp_q[k]);
      end
      step();
    end
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL a_t_end: busy=%b count=%0d, required 0 0", busy, count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_load(i);
      n_checks++;
      if (count !== 3'(i + 1) || ready !== (i < 3) || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: count=%0d ready=%b ovf=%b, required %0d %b 0",
                 i, count, ready, overflow, i + 1, i < 3);
      end
    end
    do_load(5);
    n_checks++;
    if (count !== 3'd4 || overflow !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow: count=%0d ovf=%b ready=%b, required 4 1 0", count, overflow, ready);
    end
    do_load(30);
    n_checks++;
    if (count !== 3'd4 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_full: count=%0d ovf=%b, required 4 1", count, overflow);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (count !== 3'd0 || overflow !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle: count=%0d ovf=%b ready=%b busy=%b, required 0 0 1 0",
               count, overflow, ready, busy);
    end
    do_load(30);
    n_checks++;
    if (count !== 3'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_drop: count=%0d ovf=%b, required 0 0", count, overflow);
    end
    // Full queue: a load during the fetch (pop) clock must be accepted.
    for (int i = 0; i < 4; i++) do_load(4);
    do_show();
    load = 1'b1; in_code = 5'd19;
    step();
    load = 1'b0;
    n_checks++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL load_pop_full: count=%0d ovf=%b, required 4 0", count, overflow);
    end
    do_load(4);
    n_checks++;
    if (count !== 3'd4 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL load_full_busy: count=%0d ovf=%b, required 4 1", count, overflow);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (out !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL clear_busy: out=%b busy=%b count=%0d, required 0 0 0", out, busy, count);
    end
  endtask

  task automatic test_word_space();
    int first_fall;
    int second_rise;
    bit prev;
    do_reset();
    do_load(4);
    do_load(26);
    do_load(4);
    model_letter(4, U);
    model_letter(26, U);
    model_letter(4, U);
    do_show();
    first_fall  = -1;
    second_rise = -1;
    prev        = 1'b0;
    foreach (exp_q[k]) begin
      n_checks++;
      if (out !== exp_q[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL e_sp_e cycle %0d: out=%b busy=%b, required out=%b busy=1", k, out, busy, exp_q[k]);
      end
      if (prev && out === 1'b0 && first_fall < 0) first_fall = k;
      if (!prev && out === 1'b1 && first_fall >= 0 && second_rise < 0) second_rise = k;
      prev = (out === 1'b1);
      step();
    end
    // Gap after E, four space units, gap after space, plus two fetch clocks.
    n_checks++;
    if (second_rise - first_fall != 10 * U + 2) begin
      n_fail++;
      $display("FAIL word_gap: off clocks=%0d, required %0d", second_rise - first_fall, 10 * U + 2);
    end
  endtask

  task automatic test_random();
    int nvalid;
    int code;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      nvalid = $urandom_range(1, 4);
      for (int j = 0; j < nvalid; j++) begin
        if ($urandom_range(0, 3) == 0) do_load($urandom_range(27, 31));
        code = $urandom_range(0, 26);
        do_load(code);
        model_letter(code, U);
      end
      n_checks++;
      if (count !== 3'(nvalid)) begin
        n_fail++;
        $display("FAIL rand_count it %0d: count=%0d, required %0d", it, count, nvalid);
      end
      do_show();
      foreach (exp_q[k]) begin
        n_checks++;
        if (out !== exp_q[k] || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL rand it %0d cycle %0d: out=%b busy=%b, required out=%b busy=1",
                   it, k, out, busy, exp_q[k]);
        end
        step();
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_end it %0d: busy=%b, required 0", it, busy);
      end
    end
  endtask

  task automatic test_load_during_tx();
    do_reset();
    do_load(4);
    model_letter(4, U);
    model_letter(19, U);
    do_show();
    foreach (exp_q[k]) begin
      n_checks++;
      if (out !== exp_q[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL load_tx cycle %0d: out=%b busy=%b, required out=%b busy=1", k, out, busy, exp_q[k]);
      end
      if (k == 2) begin
        load = 1'b1; in_code = 5'd19;
      end else begin
        load = 1'b0;
      end
      step();
    end
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL load_tx_end: busy=%b count=%0d, required 0 0", busy, count);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    do_load(19);
    for (int r = 0; r < 3; r++) model_letter(19, UR);
    do_show();
    foreach (exp_q[k]) begin
      n_checks++;
      if (r_out !== exp_q[k] || r_busy !== 1'b1 || r_count !== 3'd1) begin
        n_fail++;
        $display("FAIL repeat cycle %0d: out=%b busy=%b count=%0d, required out=%b busy=1 count=1",
                 k, r_out, r_busy, r_count, exp_q[k]);
      end
      step();
    end
    step();
    step();
    n_checks++;
    if (r_out !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_4th_dash: out=%b, required 1", r_out);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (r_out !== 1'b0 || r_count !== 3'd0 || r_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_clear: out=%b count=%0d busy=%b, required 0 0 0", r_out, r_count, r_busy);
    end
  endtask

  task automatic test_reset_mid_gap();
    do_reset();
    do_load(4);
    do_load(19);
    do_load(4);
    do_load(4);
    do_load(4);
    do_show();
    repeat (8) step();
    n_checks++;
    if (busy !== 1'b1 || out !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_gap: busy=%b out=%b ovf=%b, required 1 0 1", busy, out, overflow);
    end
    reset = 1'b1; load = 1'b1; in_code = 5'd2; show = 1'b1;
    step();
    reset = 1'b0; load = 1'b0; show = 1'b0;
    n_checks++;
    if ({ready, busy, overflow, count, out} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_gap: ready=%b busy=%b ovf=%b count=%0d out=%b, required 1 0 0 0 0",
               ready, busy, overflow, count, out);
    end
  endtask

  initial begin
    test_reset();
    test_single_e();
    test_two_letters();
    test_overflow();
    test_word_space();
    test_random();
    test_load_during_tx();
    test_repeat();
    test_reset_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
